// File: rtl/l1_burst_responder.sv
`timescale 1ns/1ps
// l1_burst_responder: responder end of the L1 request/return protocol.
// Reads return a line-aligned ascending burst fetched through a pipelined memory port; writes are single-word stores.
module l1_burst_responder #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l1_request,
  input  logic [31:0] l1_addr,
  input  logic        l1_rnw,
  input  logic [4:0]  l1_size,
  input  logic [31:0] l1_data,
  input  logic [3:0]  l1_be,
  output logic        l1_ack,
  output logic        l1_data_valid,
  output logic [31:0] l1_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int SZ_W  = $clog2(MAX_BURST);
  localparam int CNT_W = SZ_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] returned_q, returned_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic             dv_q;
  logic [31:0]      rdata_q;
  logic             rd_accept;
  logic             rvalid_eff;
  logic [SZ_W-1:0]  size_trunc;

  assign size_trunc = l1_size[SZ_W-1:0];

  generate
    if (SZ_W < 5) begin : g_size_hi
      logic unused_size_hi;
      assign unused_size_hi = ^l1_size[4:SZ_W];
    end
  endgenerate

  // Line span is the next power of two at or above the word count, in bytes.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input logic [SZ_W-1:0] size);
    logic [CNT_W-1:0] words;
    logic [31:0]      span;
    words = {1'b0, size} + CNT_W'(1);
    span  = 32'd4;
    for (int i = 0; i < SZ_W; i++) begin
      if ((32'd1 << i) < 32'(words)) span = span << 1;
    end
    return addr & ~(span - 32'd1);
  endfunction

  assign l1_ack        = rst && l1_request && (state_q == S_IDLE);
  assign l1_data_valid = dv_q;
  assign l1_rdata      = rdata_q;
  assign rd_accept     = (state_q == S_ISSUE) && mem_req && mem_ready;
  assign rvalid_eff    = mem_rvalid && (outst_q != '0);

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      S_ISSUE: begin
        if ((issued_q < total_q) && (outst_q < OUT_W'(MAX_OUTSTANDING))) begin
          mem_req  = 1'b1;
          mem_addr = addr_q + {{(30 - CNT_W){1'b0}}, issued_q, 2'b00};
          mem_be   = 4'hF;
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_be    = be_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    if (rvalid_eff) returned_d = returned_q + CNT_W'(1);
    case ({rd_accept, rvalid_eff})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: ;
    endcase
    case (state_q)
      S_IDLE: begin
        if (l1_ack) begin
          issued_d   = '0;
          returned_d = '0;
          state_d    = l1_rnw ? S_ISSUE : S_WRITE;
        end
      end
      S_ISSUE: begin
        if (rd_accept) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == total_q) state_d = S_DRAIN;
        end
      end
      S_WRITE: begin
        if (mem_ready) state_d = S_IDLE;
      end
      // Leave once the final return word is visible on l1_data_valid.
      S_DRAIN: begin
        if (returned_q == total_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      dv_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      dv_q       <= rvalid_eff;
      rdata_q    <= rvalid_eff ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      total_q <= '0;
    end else if (l1_ack) begin
      addr_q  <= l1_rnw ? line_base(l1_addr, size_trunc) : {l1_addr[31:2], 2'b00};
      be_q    <= l1_be;
      wdata_q <= l1_data;
      total_q <= {1'b0, size_trunc} + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(mem_rvalid && (outst_q == '0)))
        else $error("l1_burst_responder: mem_rvalid with no read outstanding");
    end
  end

endmodule

// File: tb/tb_l1_burst_responder.sv
`timescale 1ns/1ps
// Bench for l1_burst_responder: directed and randomized requests against a reactive memory
// model, with expected burst addresses/data derived from the line-alignment rule.
module tb_l1_burst_responder;
  localparam int MAXB = 16;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        l1_request = 1'b0;
  logic [31:0] l1_addr = '0;
  logic        l1_rnw = 1'b0;
  logic [4:0]  l1_size = '0;
  logic [31:0] l1_data = '0;
  logic [3:0]  l1_be = '0;
  logic        l1_ack, l1_data_valid;
  logic [31:0] l1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  l1_burst_responder #(.MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .l1_request(l1_request), .l1_addr(l1_addr), .l1_rnw(l1_rnw), .l1_size(l1_size),
    .l1_data(l1_data), .l1_be(l1_be), .l1_ack(l1_ack),
    .l1_data_valid(l1_data_valid), .l1_rdata(l1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int lat = 2;
  int ready_mode = 0;
  bit stall = 1'b0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_addr[$];
  logic [31:0] dv_data[$];
  int          dv_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_be[$];
  logic [31:0] exp_q[$];
  int          stray_ack = 0;
  int          rdata_leak = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
    end else begin
      if (l1_ack && !l1_request) stray_ack++;
      if (l1_data_valid) begin
        dv_data.push_back(l1_rdata);
        dv_cyc.push_back(cyc);
      end else if (l1_rdata !== 32'h0) begin
        rdata_leak++;
      end
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ~mem_ready;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_wdata);
          wr_be.push_back(mem_be);
        end else begin
          acc_addr.push_back(mem_addr);
          pend.push_back('{addr: mem_addr, due: cyc + lat});
        end
      end
      if (!stall && pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); dv_data.delete(); dv_cyc.delete();
    wr_addr.delete(); wr_data.delete(); wr_be.delete();
  endtask

  // Reference: words = size mod MAX_BURST + 1, aligned to the enclosing power-of-two line.
  task automatic ref_burst(input logic [31:0] a, input logic [4:0] sz);
    int words, line;
    logic [31:0] base;
    words = (int'(sz) % MAXB) + 1;
    line = 1;
    while (line < words) line = line * 2;
    base = a & ~(32'(line * 4) - 32'd1);
    for (int k = 0; k < words; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  task automatic send(input logic [31:0] a, input logic rnw, input logic [4:0] sz,
                      input logic [31:0] d, input logic [3:0] be, input bit hold, output int ack_c);
    @(posedge clk); #1;
    l1_addr = a; l1_rnw = rnw; l1_size = sz; l1_data = d; l1_be = be; l1_request = 1'b1;
    ack_c = -1;
    for (int i = 0; i < 200 && ack_c < 0; i++) begin
      @(negedge clk);
      if (l1_ack) ack_c = cyc;
    end
    if (!hold) begin
      @(posedge clk); #1;
      l1_request = 1'b0;
    end
  endtask

  task automatic wait_dv(input int n, input int budget);
    for (int i = 0; i < budget && dv_data.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic begin_read(input string tag, input logic [31:0] a, input logic [4:0] sz);
    int ack_c;
    exp_q.delete();
    ref_burst(a, sz);
    clear_logs();
    send(a, 1'b1, sz, 32'h0, 4'h0, 1'b0, ack_c);
    chk({tag, "_ack"}, 32'(ack_c >= 0), 32'd1);
  endtask

  task automatic end_read(input string tag);
    int err_a, err_d;
    wait_dv(exp_q.size(), 600);
    chk({tag, "_nacc"}, 32'(acc_addr.size()), 32'(exp_q.size()));
    chk({tag, "_ndv"}, 32'(dv_data.size()), 32'(exp_q.size()));
    err_a = 0; err_d = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= acc_addr.size() || acc_addr[k] !== exp_q[k]) err_a++;
      if (k >= dv_data.size() || dv_data[k] !== mem_word(exp_q[k])) err_d++;
    end
    chk({tag, "_addr_errs"}, 32'(err_a), 32'd0);
    chk({tag, "_data_errs"}, 32'(err_d), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack1, ack2, n1, seen;
    logic [31:0] a;
    logic [4:0]  sz;

    // Reset state, with a request pending that must not be acked.
    l1_request = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(l1_ack), 32'd0);
    chk("rst_dv", 32'(l1_data_valid), 32'd0);
    chk("rst_memreq", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_rdata", l1_rdata, 32'd0);
    l1_request = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed 8-word read, 2-cycle latency, always ready.
    lat = 2; ready_mode = 0;
    begin_read("rd8", 32'h1000_0014, 5'd7);
    chk("rd8_base", exp_q[0], 32'h1000_0000);
    end_read("rd8");

    // Returns stalled: issue stops at the outstanding limit.
    stall = 1'b1;
    begin_read("stall", 32'h1000_0014, 5'd7);
    repeat (20) @(negedge clk);
    chk("stall_nacc", 32'(acc_addr.size()), 32'(MAXO));
    chk("stall_memreq", 32'(mem_req), 32'd0);
    stall = 1'b0;
    end_read("stall");

    // 16-word read with mem_ready toggling.
    ready_mode = 1;
    begin_read("tog16", 32'h1000_0124, 5'd15);
    end_read("tog16");
    ready_mode = 0;

    // Byte-enabled single-word write.
    clear_logs();
    send(32'h2000_0006, 1'b0, 5'd0, 32'hDEAD_BEEF, 4'b1100, 1'b0, ack1);
    chk("wr_ack", 32'(ack1 >= 0), 32'd1);
    repeat (6) @(negedge clk);
    chk("wr_count", 32'(wr_addr.size()), 32'd1);
    chk("wr_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hxxxx_xxxx, 32'h2000_0004);
    chk("wr_be", wr_be.size() > 0 ? {28'd0, wr_be[0]} : 32'hxxxx_xxxx, 32'h0000_000C);
    chk("wr_data", wr_data.size() > 0 ? wr_data[0] : 32'hxxxx_xxxx, 32'hDEAD_BEEF);
    chk("wr_no_dv", 32'(dv_data.size()), 32'd0);
    chk("wr_no_rd", 32'(acc_addr.size()), 32'd0);

    // Oversized size field truncates to 4 bits: 5 words on an 8-word line.
    begin_read("trunc", 32'h1000_0234, 5'd20);
    chk("trunc_base", exp_q[0], 32'h1000_0220);
    end_read("trunc");

    // Back-to-back reads with the request held high.
    exp_q.delete();
    clear_logs();
    ref_burst(32'h1000_0308, 5'd3);
    n1 = exp_q.size();
    ref_burst(32'h1000_0444, 5'd1);
    send(32'h1000_0308, 1'b1, 5'd3, 32'h0, 4'h0, 1'b1, ack1);
    chk("b2b_ack1", 32'(ack1 >= 0), 32'd1);
    @(posedge clk); #1;
    l1_addr = 32'h1000_0444; l1_size = 5'd1;
    ack2 = -1;
    for (int i = 0; i < 300 && ack2 < 0; i++) begin
      @(negedge clk);
      if (l1_ack) ack2 = cyc;
    end
    @(posedge clk); #1;
    l1_request = 1'b0;
    chk("b2b_gap", 32'(ack2 - (dv_cyc.size() >= n1 ? dv_cyc[n1-1] : -100)), 32'd1);
    end_read("b2b");

    // Reset asserted during the third return word.
    begin_read("rstmid", 32'h1000_0040, 5'd7);
    seen = 0;
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clk);
      if (l1_data_valid) seen++;
    end
    chk("rstmid_seen3", 32'(seen), 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_dv", 32'(l1_data_valid), 32'd0);
    chk("rstmid_rdata", l1_rdata, 32'd0);
    chk("rstmid_mem", {28'd0, mem_req, mem_we, 2'b00}, 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);
    chk("rstmid_bewd", mem_wdata | {28'd0, mem_be}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    begin_read("after_rst", 32'h1000_0580, 5'd3);
    end_read("after_rst");

    // Randomized reads with random latency and random mem_ready.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      lat = int'($urandom_range(1, 4));
      a   = 32'h1000_0000 | 32'($urandom_range(0, 32'hFFFF));
      sz  = 5'($urandom_range(0, 31));
      begin_read($sformatf("rnd%0d", t), a, sz);
      end_read($sformatf("rnd%0d", t));
    end

    chk("stray_ack", 32'(stray_ack), 32'd0);
    chk("rdata_leak", 32'(rdata_leak), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
